mips_mem_arbiter: RTL

Two-requester memory arbiter that lets the Harvard CPU core's instruction-fetch port and data port share a single Avalon-style memory bus. It sits between the core and the external memory interface, serialising one word-wide transaction at a time and handling `mem_waitrequest` stalls. It returns read data and a one-cycle acknowledge to the requester that was served.

---
 rtl/mips_mem_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - instr/data port arbiter onto one Avalon-style bus (option: MIPS_MEM_ARBITER_ROUND_ROBIN_EN)
module mips_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_req,
    input  logic [ADDR_W-1:0]     instr_addr,
    output logic                  instr_ack,
    output logic [DATA_W-1:0]     instr_rdata,
    input  logic                  data_read,
    input  logic                  data_write,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    input  logic [DATA_W/8-1:0]   data_byteenable,
    output logic                  data_ack,
    output logic [DATA_W-1:0]     data_rdata,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    input  logic [DATA_W-1:0]     mem_readdata,
    input  logic                  mem_waitrequest,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, INSTR, DATA} state_t;

    state_t state;
    logic   instr_pend;
    logic   data_pend;
    logic   grant_data;

    // A requester still showing its ack has not yet had a chance to drop its request.
    assign instr_pend = instr_req & ~instr_ack;
    assign data_pend  = (data_read | data_write) & ~data_ack;

`ifdef MIPS_MEM_ARBITER_ROUND_ROBIN_EN
    // Set when data won the last grant; starts set so the first contested grant goes to instr.
    logic last_data;
    assign grant_data = data_pend & (~instr_pend | ~last_data);
`else
    assign grant_data = data_pend;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            instr_ack      <= 1'b0;
            data_ack       <= 1'b0;
            instr_rdata    <= '0;
            data_rdata     <= '0;
            mem_address    <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            mem_byteenable <= '0;
`ifdef MIPS_MEM_ARBITER_ROUND_ROBIN_EN
            last_data      <= 1'b1;
`endif
        end else begin
            instr_ack <= 1'b0;
            data_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state          <= DATA;
                        busy           <= 1'b1;
                        mem_address    <= data_addr;
                        mem_writedata  <= data_wdata;
                        mem_byteenable <= data_byteenable;
                        // Write wins when both direction bits are set.
                        mem_write      <= data_write;
                        mem_read       <= ~data_write;
`ifdef MIPS_MEM_ARBITER_ROUND_ROBIN_EN
                        last_data      <= 1'b1;
`endif
                    end else if (instr_pend) begin
                        state          <= INSTR;
                        busy           <= 1'b1;
                        mem_address    <= instr_addr;
                        mem_byteenable <= '1;
                        mem_read       <= 1'b1;
                        mem_write      <= 1'b0;
`ifdef MIPS_MEM_ARBITER_ROUND_ROBIN_EN
                        last_data      <= 1'b0;
`endif
                    end
                end
                INSTR: begin
                    if (!mem_waitrequest) begin
                        instr_rdata <= mem_readdata;
                        instr_ack   <= 1'b1;
                        mem_read    <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                DATA: begin
                    if (!mem_waitrequest) begin
                        if (mem_read) begin
                            data_rdata <= mem_readdata;
                        end
                        data_ack  <= 1'b1;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
